float_to_fixed: RTL
===================

# float_to_fixed

Pipelined converter from IEEE-754-style binary floating point (default single precision) to a signed two's-complement integer of FIXED_WIDTH bits. It is the return path of the fixed-to-float converter in the same datapath. It feeds DSP results back into fixed-point consumers (DAC/PWM/filters), with valid tagging, round-to-nearest-even, saturation and status flags.

## Interface
Parameters:
- FIXED_WIDTH, 12, output integer width (signed, two's complement)
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1
- MANT_WIDTH, 23, stored mantissa width (hidden bit implicit)

Ports:
- clk  in  1  single clock, all state on rising edge
- areset  in  1  asynchronous, active-high reset
- in_valid  in  1  a is a conversion request this cycle
- a  in  EXP_WIDTH+MANT_WIDTH+1  float input {sign, exp, mant}
- q_valid  out  1  q/flags carry a result this cycle
- q  out  FIXED_WIDTH (signed)  converted integer
- overflow  out  1  result saturated (|value| out of range or ±Inf)
- invalid  out  1  input was NaN

## Operation
- Decided interface: one clock; reset is asynchronous and active-high. Ports are clk and areset.
- No backpressure. Every in_valid=1 cycle is accepted; one result is produced per accepted input, in order.
- Stage 1, unpack/classify:
  - Split the input into sign, exp, mant.
  - Class zero: exp==0. Denormals flush to zero, result 0, no flag.
  - Class inf: exp all-ones and mant==0.
  - Class nan: exp all-ones and mant!=0.
  - Otherwise normal, significand = {1, mant}, unbiased e = exp - bias (signed, EXP_WIDTH+1 bits).
- Stage 2, align:
  - e < -1: magnitude 0, round bits 0.
  - e ≥ FIXED_WIDTH: mark overflow.
  - Otherwise shift the significand so the integer part = floor(|x|), keeping a guard bit (first dropped) and a sticky bit (OR of the rest).
  - If e > MANT_WIDTH, left-shift with guard=sticky=0.
  - Integer-part register is FIXED_WIDTH+1 bits wide.
- Stage 3, round/saturate/sign:
  - Round up when guard & (sticky | lsb): ties go to even.
  - Positive limit 2^(FIXED_WIDTH-1)-1. Negative limit magnitude 2^(FIXED_WIDTH-1).
  - Rounded magnitude above the limit for its sign, or class inf, or stage-2 overflow: q = limit with sign, overflow=1.
  - nan: q=0, invalid=1, overflow=0.
  - Else q = sign ? -mag : mag.
- Flags are per-result and valid only with q_valid. They are not sticky.

## Timing
- Latency 3 cycles: a/in_valid sampled at edge k gives q/q_valid/flags after edge k+3.
- Throughput 1 per cycle. Back-to-back inputs produce back-to-back outputs.
- q_valid is high for exactly one cycle per accepted input.
- q and the flags update only when the stage-3 valid is 1. Otherwise they hold the last result.
- Reset values: q=0, q_valid=0, overflow=0, invalid=0. All internal valid bits are 0.
- Reset asserted mid-operation discards all in-flight requests; no q_valid follows.
- The first valid output comes no earlier than 3 edges after the first in_valid sampled post-reset.
- Inputs with in_valid=0 never reach the outputs; data is don't-care.

## Structure
- Package float_fixed_pkg:
  - class enum (ZERO, NORMAL, INF, NAN)
  - BIAS localparam function
  - typedef for stage-1/stage-2 pipeline records (valid, sign, class, e/magnitude, guard, sticky)
- One sub-module, f2x_round_sat: stage 3 as a registered block.
  - Inputs: magnitude, guard, sticky, sign, class, ovf.
  - Outputs: q, overflow, invalid, q_valid.
  - It is reused later for other narrowing converters.
- Top float_to_fixed holds stages 1-2 and instantiates f2x_round_sat.

## Test plan
(FIXED_WIDTH=12)
- Single inputs, one per cycle with gaps:
  - 0x3F800000 → 1
  - 0xC0600000 (-3.5) → -4
  - 0x40200000 (2.5) → 2
  - 0x3F000000 (0.5) → 0
  - 0x3ECCCCCD (0.4) → 0
  - No flags on any. q_valid exactly 3 edges after each in_valid.
- Range limits:
  - 0x44FFE000 (2047.0) → 2047, overflow=0
  - 0x45000000 (2048.0) → 2047, overflow=1
  - 0xC5000000 (-2048.0) → -2048, overflow=0
  - 0xC4FFF000 (-2047.5) → -2048, overflow=0
  - 0x44FFF000 (2047.5) → 2047, overflow=1
- Specials:
  - 0x7F800000 → 2047, overflow=1
  - 0xFF800000 → -2048, overflow=1
  - 0x7FC00000 → 0, invalid=1
  - 0x00000001 (denormal) → 0, no flags
  - 0x80000000 → 0
- Streaming: 64 back-to-back random floats in [-3000, 3000] with in_valid=1 → 64 consecutive q_valid pulses. Values, order and flags match the reference model.
- Reset: assert areset while 3 requests are in flight, asynchronously between edges → q, q_valid and flags go 0 immediately. No q_valid for the flushed requests. The next request converts normally with 3-cycle latency.
- Hold: one valid input (0x41200000 → 10), then in_valid=0 with changing a → q stays 10 and q_valid stays 0.

Source files
------------

// File: rtl/float_fixed_pkg.sv
// Shared types for the float -> fixed narrowing converters.
package float_fixed_pkg;

  // Input classification after unpacking.
  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fclass_e;

  // Exponent bias for an exponent field of the given width.
  function automatic int bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

  // Width-independent part of every pipeline record. The parameterized
  // fields (exponent, significand, magnitude) travel alongside it.
  typedef struct packed {
    logic    vld;
    logic    sign;
    fclass_e cls;
  } f2x_tag_t;

endpackage

// File: rtl/f2x_round_sat.sv
// Registered round-to-nearest-even, saturation and sign application.
module f2x_round_sat
  import float_fixed_pkg::*;
#(
  parameter int FIXED_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          vld_i,
  input  logic                          sign_i,
  input  fclass_e                       cls_i,
  input  logic [FIXED_WIDTH:0]          mag_i,
  input  logic                          guard_i,
  input  logic                          sticky_i,
  input  logic                          ovf_i,
  output logic                          vld_o,
  output logic signed [FIXED_WIDTH-1:0] q_o,
  output logic                          ovf_o,
  output logic                          inv_o
);

  // Limits on the rounded magnitude, one bit wider than mag_i to hold the carry.
  localparam logic [FIXED_WIDTH+1:0] POS_LIM = {3'b000, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [FIXED_WIDTH+1:0] NEG_LIM = {3'b001, {(FIXED_WIDTH-1){1'b0}}};
  localparam logic [FIXED_WIDTH-1:0] Q_MAX   = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [FIXED_WIDTH-1:0] Q_MIN   = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

  logic                   rnd;
  logic [FIXED_WIDTH+1:0] mag_r;
  logic [FIXED_WIDTH-1:0] mag_f;
  logic [FIXED_WIDTH-1:0] q_d;
  logic                   ovf_d, inv_d;

  // Round, then pick saturated, NaN or signed result.
  always_comb begin
    rnd   = guard_i & (sticky_i | mag_i[0]);
    mag_r = {1'b0, mag_i} + {{(FIXED_WIDTH+1){1'b0}}, rnd};
    mag_f = mag_r[FIXED_WIDTH-1:0];
    q_d   = '0;
    ovf_d = 1'b0;
    inv_d = 1'b0;
    if (cls_i == CLS_NAN) begin
      inv_d = 1'b1;
    end else if ((cls_i == CLS_INF) || ovf_i ||
                 (mag_r > (sign_i ? NEG_LIM : POS_LIM))) begin
      ovf_d = 1'b1;
      q_d   = sign_i ? Q_MIN : Q_MAX;
    end else begin
      q_d   = sign_i ? (~mag_f + 1'b1) : mag_f;
    end
  end

  // Results only update on a valid slot; otherwise the last one holds.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vld_o <= 1'b0;
      q_o   <= '0;
      ovf_o <= 1'b0;
      inv_o <= 1'b0;
    end else begin
      vld_o <= vld_i;
      if (vld_i) begin
        q_o   <= q_d;
        ovf_o <= ovf_d;
        inv_o <= inv_d;
      end
    end
  end

endmodule

// File: rtl/float_to_fixed.sv
// Float -> signed fixed converter: input register, classify, align, then
// round/saturate in f2x_round_sat. Result appears 3 edges after sampling.
module float_to_fixed
  import float_fixed_pkg::*;
#(
  parameter int FIXED_WIDTH = 12,
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 23
) (
  input  logic                                clk,
  input  logic                                areset,
  input  logic                                in_valid,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]       a,
  output logic                                q_valid,
  output logic signed [FIXED_WIDTH-1:0]       q,
  output logic                                overflow,
  output logic                                invalid
);

  localparam int AW  = EXP_WIDTH + MANT_WIDTH + 1;
  // Aligned value scaled by 2^(MANT_WIDTH+1): integer part on top,
  // guard at bit MANT_WIDTH, sticky source below it.
  localparam int XW  = MANT_WIDTH + FIXED_WIDTH + 2;
  localparam int SHW = $clog2(FIXED_WIDTH + 1);
  localparam logic signed [EXP_WIDTH:0] BIAS_E = (EXP_WIDTH+1)'(bias(EXP_WIDTH));
  localparam logic signed [EXP_WIDTH:0] E_M1   = -1;
  localparam logic signed [EXP_WIDTH:0] E_FW   = (EXP_WIDTH+1)'(FIXED_WIDTH);

  // Input capture
  logic                in_vld_q;
  logic [AW-1:0]       a_q;

  // Stage 1 record
  f2x_tag_t                   s1_tag_d, s1_tag_q;
  logic signed [EXP_WIDTH:0]  s1_e_d, s1_e_q;
  logic [MANT_WIDTH:0]        s1_sig_d, s1_sig_q;

  // Stage 2 record
  f2x_tag_t                   s2_tag_q;
  logic [FIXED_WIDTH:0]       s2_mag_d, s2_mag_q;
  logic                       s2_g_d, s2_g_q;
  logic                       s2_s_d, s2_s_q;
  logic                       s2_ovf_d, s2_ovf_q;

  logic [EXP_WIDTH-1:0]  a_exp;
  logic [MANT_WIDTH-1:0] a_mant;
  logic [XW-1:0]         x_ext;
  logic [SHW-1:0]        sh;

  // Register the raw request; data only loads on a valid cycle.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      in_vld_q <= 1'b0;
      a_q      <= '0;
    end else begin
      in_vld_q <= in_valid;
      if (in_valid) a_q <= a;
    end
  end

  // Stage 1: unpack and classify; denormals count as zero.
  always_comb begin
    a_exp         = a_q[AW-2:MANT_WIDTH];
    a_mant        = a_q[MANT_WIDTH-1:0];
    s1_tag_d.vld  = in_vld_q;
    s1_tag_d.sign = a_q[AW-1];
    s1_e_d        = $signed({1'b0, a_exp}) - BIAS_E;
    s1_sig_d      = {1'b1, a_mant};
    if (a_exp == '0)
      s1_tag_d.cls = CLS_ZERO;
    else if (a_exp == '1)
      s1_tag_d.cls = (a_mant != '0) ? CLS_NAN : CLS_INF;
    else
      s1_tag_d.cls = CLS_NORMAL;
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s1_tag_q <= '0;
      s1_e_q   <= '0;
      s1_sig_q <= '0;
    end else begin
      s1_tag_q <= s1_tag_d;
      s1_e_q   <= s1_e_d;
      s1_sig_q <= s1_sig_d;
    end
  end

  // Stage 2: shift the significand left by e+1 into the scaled field; this
  // covers both the right-shift (fraction kept as guard/sticky) and the
  // pure left-shift case where guard and sticky fall out as zero.
  always_comb begin
    s2_mag_d = '0;
    s2_g_d   = 1'b0;
    s2_s_d   = 1'b0;
    s2_ovf_d = 1'b0;
    x_ext    = '0;
    sh       = '0;
    if (s1_tag_q.cls == CLS_NORMAL) begin
      if (s1_e_q >= E_FW) begin
        s2_ovf_d = 1'b1;
      end else if (s1_e_q >= E_M1) begin
        sh       = SHW'(s1_e_q - E_M1);
        x_ext    = XW'(s1_sig_q) << sh;
        s2_mag_d = x_ext[XW-1 -: FIXED_WIDTH+1];
        s2_g_d   = x_ext[MANT_WIDTH];
        s2_s_d   = |x_ext[MANT_WIDTH-1:0];
      end
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s2_tag_q <= '0;
      s2_mag_q <= '0;
      s2_g_q   <= 1'b0;
      s2_s_q   <= 1'b0;
      s2_ovf_q <= 1'b0;
    end else begin
      s2_tag_q <= s1_tag_q;
      s2_mag_q <= s2_mag_d;
      s2_g_q   <= s2_g_d;
      s2_s_q   <= s2_s_d;
      s2_ovf_q <= s2_ovf_d;
    end
  end

  f2x_round_sat #(.FIXED_WIDTH(FIXED_WIDTH)) u_round_sat (
    .clk      (clk),
    .areset   (areset),
    .vld_i    (s2_tag_q.vld),
    .sign_i   (s2_tag_q.sign),
    .cls_i    (s2_tag_q.cls),
    .mag_i    (s2_mag_q),
    .guard_i  (s2_g_q),
    .sticky_i (s2_s_q),
    .ovf_i    (s2_ovf_q),
    .vld_o    (q_valid),
    .q_o      (q),
    .ovf_o    (overflow),
    .inv_o    (invalid)
  );

endmodule
